// File: rtl/cpu_mtimer.sv
// cpu_mtimer: memory-mapped 64-bit machine timer with prescaler; MTIMER_MSIP_EN adds the msip register
module cpu_mtimer #(
  parameter int XLEN = 32,
  parameter int PRESC_W = 16,
  parameter int unsigned PRESC_RESET = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req,
  input  logic            we,
  input  logic [4:0]      addr,
  input  logic [XLEN-1:0] wdata,
  input  logic [3:0]      wstrb,
  output logic [XLEN-1:0] rdata,
  output logic            rvalid,
  output logic            mti_pending,
  output logic            msi_pending
);
  logic [63:0]        r_mtime, r_mtimecmp;
  logic [PRESC_W-1:0] r_div, r_presc;
  logic [XLEN-1:0]    r_rdata;
  logic               r_rvalid, r_mti;
  logic               w_wr, w_tick, w_div_wr;
  logic [2:0]         w_off;
  logic [63:0]        w_mtime_nx, w_cmp_nx;
  logic [PRESC_W-1:0] w_div_nx, w_presc_nx;
  logic [31:0]        w_msip_rd, w_rd;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    for (int i = 0; i < 4; i++) merge[8*i +: 8] = s[i] ? d[8*i +: 8] : old[8*i +: 8];
  endfunction

  // Next-state values: a written mtime half replaces the tick result and suppresses any carry
  always_comb begin
    w_off = addr[4:2];
    w_wr = req & we & (|wstrb);
    w_tick = r_presc == r_div;
    w_div_wr = w_wr && w_off == 3'd4;
    w_mtime_nx = (w_wr && w_off == 3'd0) ? {r_mtime[63:32], merge(r_mtime[31:0], wdata, wstrb)} :
                 (w_wr && w_off == 3'd1) ? {merge(r_mtime[63:32], wdata, wstrb), r_mtime[31:0]} :
                 r_mtime + 64'(w_tick);
    w_cmp_nx = (w_wr && w_off == 3'd2) ? {r_mtimecmp[63:32], merge(r_mtimecmp[31:0], wdata, wstrb)} :
               (w_wr && w_off == 3'd3) ? {merge(r_mtimecmp[63:32], wdata, wstrb), r_mtimecmp[31:0]} :
               r_mtimecmp;
    w_div_nx = r_div;
    for (int b = 0; b < PRESC_W; b++) w_div_nx[b] = (w_div_wr && wstrb[b/8]) ? wdata[b] : r_div[b];
    w_presc_nx = (w_div_wr || w_tick) ? '0 : r_presc + 1'b1;
    w_rd = (w_off == 3'd0) ? r_mtime[31:0] :
           (w_off == 3'd1) ? r_mtime[63:32] :
           (w_off == 3'd2) ? r_mtimecmp[31:0] :
           (w_off == 3'd3) ? r_mtimecmp[63:32] :
           (w_off == 3'd4) ? 32'(r_div) :
           (w_off == 3'd5) ? w_msip_rd : 32'd0;
  end

  // Timer state, interrupt compare on next-state values, and registered read response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mtime <= '0;
      r_mtimecmp <= '1;
      r_div <= PRESC_W'(PRESC_RESET);
      r_presc <= '0;
      r_rdata <= '0;
      r_rvalid <= 1'b0;
      r_mti <= 1'b0;
    end else begin
      r_mtime <= w_mtime_nx;
      r_mtimecmp <= w_cmp_nx;
      r_div <= w_div_nx;
      r_presc <= w_presc_nx;
      r_mti <= w_mtime_nx >= w_cmp_nx;
      r_rvalid <= req & ~we;
      if (req && !we) r_rdata <= w_rd;
    end
  end

`ifdef MTIMER_MSIP_EN
  logic r_msip;
  // Software interrupt flag, written through byte 0 of its register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_msip <= 1'b0;
    else if (w_wr && w_off == 3'd5 && wstrb[0]) r_msip <= wdata[0];
  end
  assign w_msip_rd = {31'd0, r_msip};
  assign msi_pending = r_msip;
`else
  assign w_msip_rd = 32'd0;
  assign msi_pending = 1'b0;
`endif

  assign rdata = r_rdata;
  assign rvalid = r_rvalid;
  assign mti_pending = r_mti;
endmodule

// File: tb/tb_cpu_mtimer.sv
// tb_cpu_mtimer: directed and random bus traffic checked against a behavioural timer model
module tb_cpu_mtimer;
  logic clk = 0, rst_n = 0, req = 0, we = 0;
  logic [4:0] addr = 0;
  logic [31:0] wdata = 0;
  logic [3:0] wstrb = 0;
  logic [31:0] rdata;
  logic rvalid, mti_pending, msi_pending;

  cpu_mtimer dut (.clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
                  .wstrb(wstrb), .rdata(rdata), .rvalid(rvalid), .mti_pending(mti_pending),
                  .msi_pending(msi_pending));

  always #5 clk = ~clk;

`ifdef MTIMER_MSIP_EN
  localparam bit MSIP = 1;
`else
  localparam bit MSIP = 0;
`endif

  int n_chk = 0, n_fail = 0;
  logic [63:0] m_mtime, m_cmp;
  longint unsigned m_div, m_since;
  bit m_msip, e_rvalid, e_mti;
  logic [31:0] e_rdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mrg(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] rd(input logic [4:0] a);
    case (a >> 2)
      0: return m_mtime[31:0];
      1: return m_mtime[63:32];
      2: return m_cmp[31:0];
      3: return m_cmp[63:32];
      4: return 32'(m_div);
      5: return MSIP ? {31'd0, m_msip} : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic mreset();
    m_mtime = 0; m_cmp = '1; m_div = 0; m_since = 0; m_msip = 0;
    e_rdata = 0; e_rvalid = 0; e_mti = 0;
  endtask

  task automatic cyc(input bit r, input bit w, input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    bit tick, wr;
    logic [63:0] nt;
    logic [31:0] nd;
    int off;
    req = r; we = w; addr = a; wdata = d; wstrb = s;
    @(posedge clk);
    e_rvalid = r && !w;
    if (e_rvalid) e_rdata = rd(a);
    tick = (m_since % (m_div + 1)) == m_div;
    nt = m_mtime + 64'(tick);
    wr = r && w && s != 0;
    off = int'(a >> 2);
    m_since = m_since + 1;
    if (wr) begin
      if (off == 0) nt = {m_mtime[63:32], mrg(m_mtime[31:0], d, s)};
      if (off == 1) nt = {mrg(m_mtime[63:32], d, s), m_mtime[31:0]};
      if (off == 2) m_cmp[31:0] = mrg(m_cmp[31:0], d, s);
      if (off == 3) m_cmp[63:32] = mrg(m_cmp[63:32], d, s);
      if (off == 4) begin
        nd = mrg(32'(m_div), d, s);
        m_div = nd[15:0];
        m_since = 0;
      end
      if (off == 5 && s[0]) m_msip = d[0];
    end
    m_mtime = nt;
    e_mti = m_mtime >= m_cmp;
    @(negedge clk);
    chk("rvalid", rvalid, e_rvalid);
    chk("rdata", rdata, e_rdata);
    chk("mti_pending", mti_pending, e_mti);
    chk("msi_pending", msi_pending, MSIP & m_msip);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0, 0);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    cyc(1, 1, a, d, 4'hF);
  endtask

  task automatic rdc(input logic [4:0] a);
    cyc(1, 0, a, 0, 0);
  endtask

  initial begin
    mreset();
    #1;
    chk("reset_rvalid", rvalid, 0);
    chk("reset_rdata", rdata, 0);
    chk("reset_mti", mti_pending, 0);
    chk("reset_msi", msi_pending, 0);
    @(negedge clk);
    rst_n = 1;
    idle(10);
    rdc(5'h00);
    chk("mtime_after_10", rdata, 32'd10);
    idle(1);
    wr(5'h10, 3);
    wr(5'h00, 0);
    idle(40);
    rdc(5'h00);
    rdc(5'h10);
    wr(5'h10, 0);
    wr(5'h04, 0);
    wr(5'h00, 32'hFFFF_FFFF);
    idle(1);
    rdc(5'h04);
    chk("carry_high", rdata, 32'd1);
    rdc(5'h00);
    wr(5'h0C, 0);
    wr(5'h08, 32'h20);
    wr(5'h00, 0);
    wr(5'h04, 0);
    idle(40);
    chk("mti_set", mti_pending, 1);
    wr(5'h0C, 1);
    chk("mti_clear", mti_pending, 0);
    wr(5'h00, 32'h100);
    rdc(5'h00);
    chk("write_beats_tick", rdata, 32'h100);
    wr(5'h08, 32'hFFFF_FFFF);
    cyc(1, 1, 5'h08, 32'h0000_00AB, 4'b0001);
    rdc(5'h08);
    chk("byte_merge", rdata, 32'hFFFF_FFAB);
    cyc(1, 1, 5'h00, 0, 4'b0000);
    rdc(5'h00);
    wr(5'h14, 1);
    chk("msip_set", msi_pending, MSIP);
    rdc(5'h14);
    chk("msip_read", rdata, {31'd0, MSIP});
    wr(5'h14, 0);
    chk("msip_clear", msi_pending, 0);
    wr(5'h18, 32'h1234);
    rdc(5'h18);
    rdc(5'h1C);
    for (int i = 0; i < 400; i++) begin
      int op = $urandom_range(0, 9);
      logic [4:0] a = 5'($urandom_range(0, 7) << 2) | 5'($urandom_range(0, 3));
      logic [31:0] d = $urandom;
      logic [3:0] s = $urandom_range(0, 3) == 0 ? 4'($urandom) : 4'hF;
      if (a[4:2] == 3'd2) d = m_mtime[31:0] + $urandom_range(0, 40);
      if (a[4:2] == 3'd3) d = m_mtime[63:32] + $urandom_range(0, 1);
      if (a[4:2] == 3'd4) d = $urandom_range(0, 4);
      if (a[4:2] <= 3'd1 && $urandom_range(0, 3) != 0) d = $urandom_range(0, 64);
      if (op < 4) idle(1);
      else if (op < 7) rdc(a);
      else cyc(1, 1, a, d, s);
    end
    req = 1; we = 0; addr = 5'h00;
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("async_rvalid", rvalid, 0);
    chk("async_rdata", rdata, 0);
    chk("async_mti", mti_pending, 0);
    chk("async_msi", msi_pending, 0);
    mreset();
    req = 0;
    @(negedge clk);
    rst_n = 1;
    idle(3);
    rdc(5'h00);
    rdc(5'h0C);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
